// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared pixel width default and 3x3 window index constants
package cnn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int WIN_N      = 9;
  localparam int WIN_COLS   = 3;

  // Row offsets into the flattened, row-major 3x3 window
  localparam int WIN_TOP = 0;
  localparam int WIN_MID = 3;
  localparam int WIN_BOT = 6;

endpackage

// File: rtl/window_gen_3x3_if.sv
// rtl/window_gen_3x3_if.sv - raster pixel input and 3x3 window output bundle
interface window_gen_3x3_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic signed [DATA_W-1:0] pixel_in;
  logic                     valid_in;
  logic                     sof;
  logic signed [DATA_W-1:0] window [WIN_N];
  logic                     valid_out;
  logic                     frame_done;

  modport master (
    output pixel_in, valid_in, sof,
    input  window, valid_out, frame_done
  );

  modport slave (
    input  pixel_in, valid_in, sof,
    output window, valid_out, frame_done
  );

endinterface

// File: rtl/line_fifo.sv
// rtl/line_fifo.sv - fixed-delay line buffer: dout is the din accepted DEPTH enables ago
module line_fifo #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]            ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

  // Storage is never cleared; stale entries are masked by the window counters
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  assign dout = mem[ptr];

endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - 3x3 sliding window generator over a raster pixel stream
module window_gen_3x3
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  window_gen_3x3_if.slave   bus
);

  localparam int            CW       = $clog2(IMG_W);
  localparam int            RW       = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          accept;
  logic          win_hit;

  logic signed [DATA_W-1:0] lb1_dout;
  logic signed [DATA_W-1:0] lb2_dout;
  logic signed [DATA_W-1:0] sh      [WIN_N];
  logic signed [DATA_W-1:0] sh_next [WIN_N];

  assign accept  = bus.valid_in;
  // sof pins the current pixel to the frame origin regardless of counter state
  assign cur_col = bus.sof ? '0 : col;
  assign cur_row = bus.sof ? '0 : row;
  assign win_hit = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  line_fifo #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .din   (bus.pixel_in),
    .dout  (lb1_dout)
  );

  line_fifo #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb2 (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .din   (lb1_dout),
    .dout  (lb2_dout)
  );

  always_comb begin
    for (int r = 0; r < WIN_COLS; r++) begin
      sh_next[r*WIN_COLS]     = sh[r*WIN_COLS + 1];
      sh_next[r*WIN_COLS + 1] = sh[r*WIN_COLS + 2];
    end
    sh_next[WIN_TOP + 2] = lb2_dout;
    sh_next[WIN_MID + 2] = lb1_dout;
    sh_next[WIN_BOT + 2] = bus.pixel_in;
  end

  // The shift array moves on every accepted pixel; the output copy only on valid windows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WIN_N; k++) begin
        sh[k]         <= '0;
        bus.window[k] <= '0;
      end
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.valid_out  <= win_hit;
      bus.frame_done <= win_hit && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (accept) begin
        sh <= sh_next;
      end
      if (win_hit) begin
        bus.window <= sh_next;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - randomized and directed bench with an image-array window model
module tb_window_gen_3x3;
  import cnn_pkg::*;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int DW = 16;

  typedef logic [WIN_N-1:0][DW-1:0] win_p;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  window_gen_3x3_if #(.DATA_W(DW)) bs ();
  window_gen_3x3_if #(.DATA_W(DW)) bb ();

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bs)
  );

  window_gen_3x3 #(.DATA_W(DW)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bb)
  );

  int checks   = 0;
  int failures = 0;
  int big_win  = 0;
  int big_done = 0;
  win_p got_q[$];
  bit   done_q[$];

  // Model: place each accepted pixel in its image position, read windows from the image
  logic signed [DW-1:0] img [H][W];
  int   pos;
  int   cur, cur_r, cur_c;
  win_p e_win;
  logic e_valid, e_done;

  assign cur   = bs.sof ? 0 : pos;
  assign cur_r = cur / W;
  assign cur_c = cur % W;

  function automatic win_p model_win(input int r, input int c, input logic signed [DW-1:0] pix);
    win_p w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i*3+j] = (i == 2 && j == 2) ? pix : img[r-2+i][c-2+j];
    return w;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pos     <= 0;
      e_valid <= 1'b0;
      e_done  <= 1'b0;
      e_win   <= '0;
    end else begin
      e_valid <= 1'b0;
      e_done  <= 1'b0;
      if (bs.valid_in) begin
        img[cur_r][cur_c] <= bs.pixel_in;
        pos <= (cur + 1) % (W*H);
        if (cur_r >= 2 && cur_c >= 2) begin
          e_valid <= 1'b1;
          e_done  <= (cur == W*H - 1);
          e_win   <= model_win(cur_r, cur_c, bs.pixel_in);
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input win_p act, input win_p exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic win_p pk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    win_p w;
    w[0] = DW'(a0); w[1] = DW'(a1); w[2] = DW'(a2);
    w[3] = DW'(a3); w[4] = DW'(a4); w[5] = DW'(a5);
    w[6] = DW'(a6); w[7] = DW'(a7); w[8] = DW'(a8);
    return w;
  endfunction

  function automatic win_p dut_win();
    win_p w;
    for (int k = 0; k < WIN_N; k++) w[k] = bs.window[k];
    return w;
  endfunction

  // Per-cycle comparison of the small DUT against the model, plus big-DUT tallies
  task automatic compare();
    chk("valid_out", bs.valid_out, e_valid);
    chk("frame_done", bs.frame_done, e_done);
    chk_win("window", dut_win(), e_win);
    if (bs.valid_out) begin
      got_q.push_back(dut_win());
      done_q.push_back(bs.frame_done);
    end
    if (bb.valid_out) big_win++;
    if (bb.frame_done) big_done++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic s, input int p);
    bs.valid_in = v;
    bs.sof      = s;
    bs.pixel_in = DW'(p);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
  endtask

  task automatic clear_q();
    got_q.delete();
    done_q.delete();
  endtask

  task automatic check_ramp(input string nm, input int b);
    chk({nm, "_count"}, got_q.size(), 9);
    if (got_q.size() == 9) begin
      chk_win({nm, "_first"}, got_q[0], pk9(b+0, b+1, b+2, b+5, b+6, b+7, b+10, b+11, b+12));
      chk_win({nm, "_last"}, got_q[8], pk9(b+12, b+13, b+14, b+17, b+18, b+19, b+22, b+23, b+24));
      chk({nm, "_last_done"}, done_q[8], 1);
      chk({nm, "_early_done"}, done_q[0] | done_q[7], 0);
    end
  endtask

  initial begin
    bs.valid_in = 1'b0; bs.sof = 1'b0; bs.pixel_in = '0;
    bb.valid_in = 1'b0; bb.sof = 1'b0; bb.pixel_in = '0;
    @(posedge clk);
    #2;
    tick();
    tick();
    chk("reset_valid_out", bs.valid_out, 0);
    chk("reset_frame_done", bs.frame_done, 0);
    chk_win("reset_window", dut_win(), pk9(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick();

    // Continuous ramp
    clear_q();
    for (int i = 0; i < 25; i++) drive(1'b1, i == 0, i);
    idle(2);
    check_ramp("ramp", 0);

    // Same ramp with three idle cycles after every pixel
    clear_q();
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, i == 0, i);
      idle(3);
    end
    check_ramp("gapped", 0);

    // Signed extremes with random gaps and occasional sof
    for (int i = 0; i < 300; i++) begin
      int p;
      case ($urandom_range(0, 3))
        0: p = -32768;
        1: p = 32767;
        2: p = -1;
        default: p = int'($urandom_range(0, 65535)) - 32768;
      endcase
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, p);
    end
    idle(2);

    // Reset after pixel 10 aborts the frame
    for (int i = 0; i < 11; i++) drive(1'b1, i == 0, i);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_q();
    for (int i = 0; i < 25; i++) drive(1'b1, i == 0, 100 + i);
    idle(2);
    check_ramp("after_reset", 100);

    // sof reasserted at pixel 7 resynchronises the counters
    clear_q();
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 300 + i);
    for (int i = 0; i < 25; i++) drive(1'b1, i == 0, 200 + i);
    idle(2);
    check_ramp("resync", 200);

    // Default 28x28 instance, two back-to-back frames
    for (int i = 0; i < 2*28*28; i++) begin
      if (i == 28*28 + 1) begin
        chk("big_frame1_windows", big_win, 676);
        chk("big_frame1_done", big_done, 1);
      end
      bb.valid_in = 1'b1;
      bb.sof      = (i == 0);
      bb.pixel_in = DW'($urandom);
      tick();
    end
    bb.valid_in = 1'b0;
    bb.sof      = 1'b0;
    idle(3);
    chk("big_total_windows", big_win, 1352);
    chk("big_total_done", big_done, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_W, default 28, pixels per image row (>=3).
REQ-002 Parameter IMG_H, default 28, rows per image (>=3).
REQ-003 Parameter DATA_W, default 16, pixel width, signed two's complement.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pixel_in  input  DATA_W signed  raster-order pixel, row-major, left to right.
REQ-007 valid_in  input  1  pixel_in valid this cycle.
REQ-008 sof  input  1  start of frame; qualified by valid_in.
REQ-009 window  output  DATA_W signed x9 (index 0..8)  3x3 window, row-major: 0..2 top row, 3..5 middle row, 6..8 bottom row, left to right.
REQ-010 valid_out  output  1  window valid, single-cycle pulse per window.
REQ-011 frame_done  output  1  pulses with the valid_out of the frame's last window.

Function
REQ-012 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advancing only on cycles with valid_in=1.
REQ-013 col SHALL wrap IMG_W-1 -> 0 with row incrementing; at row=IMG_H-1, col=IMG_W-1 both SHALL wrap to 0.
REQ-014 valid_in=1 with sof=1 SHALL treat pixel_in as row 0, col 0 regardless of counter state; the counters then advance from that position.
REQ-015 Cycles with valid_in=0 SHALL leave counters, line buffers and window registers unchanged.
REQ-016 Two line buffers of IMG_W entries SHALL hold the previous two rows; each accepted pixel SHALL shift in, delayed by exactly IMG_W and 2*IMG_W accepted pixels.
REQ-017 A 3x3 register array SHALL shift one column left per accepted pixel; the new right column is {line buffer 2 output, line buffer 1 output, pixel_in} as {top, middle, bottom}.
REQ-018 For an accepted pixel at (row, col), window[8] SHALL equal that pixel and window[0] SHALL equal the pixel at (row-2, col-2).
REQ-019 valid_out SHALL be 1 exactly one cycle after an accepted pixel with row>=2 and col>=2, otherwise 0; no padding, so (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-020 Latency SHALL be 1 clock from the accepted pixel to window/valid_out.
REQ-021 window SHALL hold its last value while valid_out=0.
REQ-022 frame_done SHALL be 1 exactly in the cycle valid_out reports the window for (IMG_H-1, IMG_W-1).
REQ-023 Pixel values SHALL pass unmodified (no arithmetic, sign preserved).
REQ-024 There SHALL be no backpressure; downstream consumes every valid_out pulse.

Reset
REQ-025 reset SHALL asynchronously clear col, row, valid_out and frame_done to 0, and window to all zeros.
REQ-026 Line buffer contents SHALL NOT need clearing; no window built from pre-reset data SHALL be marked valid, because valid_out depends only on counters.
REQ-027 Reset asserted mid-frame SHALL abort the frame; the first accepted pixel after release is row 0, col 0.

Structure
REQ-028 DATA_W default and the window index constants (TOP/MID/BOT row offsets) SHALL reside in shared package cnn_pkg.
REQ-029 Each line buffer SHALL be an instance of sub-module line_fifo (parameters DEPTH, DATA_W; ports clk, reset, en, din, dout).
REQ-030 The block SHALL be synthesizable with no latches and be sized at 120-400 RTL lines.

Verification (IMG_W=5, IMG_H=5 unless stated)
REQ-031 Ramp pixels 0..24, continuous valid_in, sof on pixel 0 -> first valid_out one cycle after pixel 12, window={0,1,2,5,6,7,10,11,12}; 9 windows total; last window={12,13,14,17,18,19,22,23,24} with frame_done=1.
REQ-032 Same ramp with valid_in=0 for 3 cycles after every accepted pixel -> identical 9 windows in order; valid_out never high in gap cycles except the 1-cycle-latency slot.
REQ-033 Pixels -32768, 32767, -1 mixed -> window values bit-identical to inputs, sign preserved.
REQ-034 Reset asserted after pixel 10, then a new ramp 100..124 with sof -> no valid_out before the new pixel 112; first window={100,101,102,105,106,107,110,111,112}.
REQ-035 sof reasserted at pixel 7 of a frame -> counters resync; first valid_out one cycle after the 13th pixel counted from that sof.
REQ-036 Default parameters 28x28, two back-to-back frames -> exactly 676 valid_out and 1 frame_done per frame.
